ram_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of `ram_fsm`. It buffers read/write requests in a small FIFO and issues them one at a time over the FSM's `start`/`rw`/`addr`/`data_in` handshake, holding operands stable until `done`. It returns read data on a valid/ready response port. A watchdog drops any operation that never completes and flags an error.

---
 rtl/ram_cmd_seq.sv | 219 +++++++++++++++++++++
 tb/tb_ram_cmd_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cmd_seq.sv
// ram_cmd_seq
// Command sequencer sitting in front of ram_fsm. Read/write requests are
// buffered in a small FIFO and issued one at a time over the start/rw/addr/
// data_in handshake. Operands stay frozen until the FSM has dropped done.
// Read data comes back on a valid/ready response port. A watchdog abandons
// any operation that never completes and raises a sticky error flag.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command push handshake (cmd_ready = !full)
//   cmd_rw/addr/wdata       command fields (rw: 1 = read, 0 = write)
//   fsm_start               one-cycle start pulse to ram_fsm
//   fsm_rw/addr/data_in     operands to ram_fsm, stable for the whole op
//   fsm_data_out, fsm_done  result and completion from ram_fsm
//   rsp_valid/rsp_ready     read response handshake
//   rsp_data, rsp_addr      read data and the address it came from
//   busy                    sequencer active or commands pending
//   count                   FIFO occupancy
//   err_timeout             sticky watchdog expiry flag
module ram_cmd_seq #(
    parameter int DEPTH   = 4,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rw,
    input  logic [AW-1:0]          cmd_addr,
    input  logic [DW-1:0]          cmd_wdata,
    output logic                   fsm_start,
    output logic                   fsm_rw,
    output logic [AW-1:0]          fsm_addr,
    output logic [DW-1:0]          fsm_data_in,
    input  logic [DW-1:0]          fsm_data_out,
    input  logic                   fsm_done,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DW-1:0]          rsp_data,
    output logic [AW-1:0]          rsp_addr,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_timeout
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(TIMEOUT);
    localparam int EW = 1 + AW + DW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic            fsm_start_q, fsm_start_d;
    logic            fsm_rw_q, fsm_rw_d;
    logic [AW-1:0]   fsm_addr_q, fsm_addr_d;
    logic [DW-1:0]   fsm_data_in_q, fsm_data_in_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic [AW-1:0]   rsp_addr_q, rsp_addr_d;
    logic            err_timeout_q, err_timeout_d;

    logic [EW-1:0]   fifo_mem_q [DEPTH];
    logic [EW-1:0]   head_entry;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign push       = cmd_valid && !full;
    assign pop        = (state_q == S_IDLE) && !empty;
    assign head_entry = fifo_mem_q[rd_ptr_q];

    // FIFO storage needs no reset: the pointers and count define which
    // entries are meaningful, so a reset simply forgets the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_rw, cmd_addr, cmd_wdata};
        end
    end

    // Next-state logic. The operand registers only change on a pop in IDLE,
    // which keeps them frozen from issue until RELEASE hands back to IDLE.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        wd_d          = wd_q;
        fsm_start_d   = 1'b0;
        fsm_rw_d      = fsm_rw_q;
        fsm_addr_d    = fsm_addr_q;
        fsm_data_in_d = fsm_data_in_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_addr_d    = rsp_addr_q;
        err_timeout_d = err_timeout_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {fsm_rw_d, fsm_addr_d, fsm_data_in_d} = head_entry;
                    fsm_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WW'(1);
                // A completion in the final watchdog cycle still counts.
                if (fsm_done) begin
                    if (fsm_rw_q) begin
                        rsp_data_d  = fsm_data_out;
                        rsp_addr_d  = fsm_addr_q;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_RELEASE;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Waiting for done to fall stops a level-held done from
                // instantly completing the next command.
                if (!fsm_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wd_q          <= '0;
            fsm_start_q   <= 1'b0;
            fsm_rw_q      <= 1'b0;
            fsm_addr_q    <= '0;
            fsm_data_in_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_addr_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            wd_q          <= wd_d;
            fsm_start_q   <= fsm_start_d;
            fsm_rw_q      <= fsm_rw_d;
            fsm_addr_q    <= fsm_addr_d;
            fsm_data_in_q <= fsm_data_in_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_addr_q    <= rsp_addr_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign cmd_ready   = !full;
    assign busy        = (state_q != S_IDLE) || !empty;
    assign count       = count_q;
    assign fsm_start   = fsm_start_q;
    assign fsm_rw      = fsm_rw_q;
    assign fsm_addr    = fsm_addr_q;
    assign fsm_data_in = fsm_data_in_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_addr    = rsp_addr_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ram_cmd_seq.sv
// tb_ram_cmd_seq
// Bench for ram_cmd_seq. A behavioural stand-in for ram_fsm plus RAM answers
// each start after a programmable delay, holds done for a programmable number
// of cycles, or never answers at all. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
module tb_ram_cmd_seq;

    localparam int DEPTH   = 4;
    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_rw = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          fsm_start;
    logic          fsm_rw;
    logic [AW-1:0] fsm_addr;
    logic [DW-1:0] fsm_data_in;
    logic [DW-1:0] fsm_data_out = '0;
    logic          fsm_done = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          busy;
    logic [2:0]    count;
    logic          err_timeout;

    int check_count = 0;
    int fail_count  = 0;

    // Stand-in memory controller state
    logic [7:0] stub_mem [256];
    int         stub_delay   = 2;
    int         stub_hold    = 1;
    int         stub_skip    = 0;
    int         dly_cnt      = 0;
    int         hold_cnt     = 0;
    int         stale_starts = 0;
    logic       op_rw = 1'b0;
    logic [7:0] op_addr = '0;
    logic [7:0] op_data = '0;

    // Activity monitor
    int          start_count = 0;
    int          push_count  = 0;
    int          peak_count  = 0;
    logic [15:0] rsp_q [$];

    ram_cmd_seq #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rw       (cmd_rw),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .fsm_start    (fsm_start),
        .fsm_rw       (fsm_rw),
        .fsm_addr     (fsm_addr),
        .fsm_data_in  (fsm_data_in),
        .fsm_data_out (fsm_data_out),
        .fsm_done     (fsm_done),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_addr     (rsp_addr),
        .busy         (busy),
        .count        (count),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    // Memory controller model: latches operands on start, raises done
    // stub_delay cycles later for stub_hold cycles, unless told to ignore
    // the start. A start seen while done is still high is recorded.
    always @(negedge clk) begin
        if (!reset_n) begin
            dly_cnt  = 0;
            hold_cnt = 0;
            fsm_done = 1'b0;
        end else begin
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) fsm_done = 1'b0;
            end
            if (dly_cnt > 0) begin
                dly_cnt--;
                if (dly_cnt == 0) begin
                    fsm_done = 1'b1;
                    hold_cnt = stub_hold;
                    if (op_rw) fsm_data_out = stub_mem[op_addr];
                    else       stub_mem[op_addr] = op_data;
                end
            end
            if (fsm_start) begin
                if (fsm_done) stale_starts++;
                op_rw   = fsm_rw;
                op_addr = fsm_addr;
                op_data = fsm_data_in;
                if (stub_skip > 0) stub_skip--;
                else               dly_cnt = stub_delay;
            end
        end
    end

    // Records start pulses, accepted pushes, responses and peak occupancy.
    always @(posedge clk) begin
        if (reset_n) begin
            if (fsm_start) start_count++;
            if (cmd_valid && cmd_ready) push_count++;
            if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_addr, rsp_data});
            if (int'(count) > peak_count) peak_count = int'(count);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offers one command starting at a falling edge; returns at the falling
    // edge after the accepting rising edge.
    task automatic applyStimulus(input logic rw, input logic [7:0] addr, input logic [7:0] wdata);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("pushAccepted", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || fsm_done) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("waitIdle", busy, 0);
    endtask

    task automatic waitStart();
        int n = 0;
        while (!fsm_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("waitStart", fsm_start, 1);
    endtask

    task automatic popRsp(output logic [15:0] r);
        if (rsp_q.size() > 0) r = rsp_q.pop_front();
        else                  r = 16'hxxxx;
    endtask

    initial begin
        int          s0;
        int          s1;
        int          st0;
        int          k;
        int          n;
        logic [15:0] r;

        for (int i = 0; i < 256; i++) stub_mem[i] = 8'(i + 32'h40);
        stub_mem[8'h10] = 8'h3C;

        // Reset values
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rstReady", cmd_ready, 1);
        checkOutput("rstCount", count, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstFsm", {fsm_start, fsm_rw, fsm_addr, fsm_data_in}, 0);
        checkOutput("rstRsp", {rsp_valid, rsp_addr, rsp_data}, 0);
        checkOutput("rstErr", err_timeout, 0);

        // Write then read, with issue timing after a push into an empty FIFO
        $display("[TB] write then read");
        s0 = start_count;
        applyStimulus(1'b0, 8'h05, 8'hAA);
        checkOutput("pushCount", count, 1);
        checkOutput("noEarlyStart", fsm_start, 0);
        @(negedge clk);
        checkOutput("issueStart", fsm_start, 1);
        checkOutput("issueCount", count, 0);
        checkOutput("issueOperands", {fsm_rw, fsm_addr, fsm_data_in}, {1'b0, 8'h05, 8'hAA});
        @(negedge clk);
        checkOutput("startOneCycle", fsm_start, 0);
        waitIdle();
        applyStimulus(1'b1, 8'h05, 8'h00);
        waitIdle();
        checkOutput("wrStarts", start_count - s0, 2);
        checkOutput("wrRspCount", rsp_q.size(), 1);
        popRsp(r);
        checkOutput("wrRspValue", r, {8'h05, 8'hAA});
        checkOutput("wrRspHeld", {rsp_addr, rsp_data}, {8'h05, 8'hAA});

        // FIFO full with the response port stalled
        $display("[TB] fifo full");
        rsp_ready  = 1'b0;
        s0         = start_count;
        s1         = push_count;
        peak_count = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(32'h20 + i), 8'h00);
            end
            begin
                repeat (20) @(negedge clk);
                checkOutput("fullCount", count, 4);
                checkOutput("fullReady", cmd_ready, 0);
                checkOutput("fullPushes", push_count - s1, 5);
                checkOutput("fullRspValid", rsp_valid, 1);
                rsp_ready = 1'b1;
            end
        join
        waitIdle();
        checkOutput("fullPeak", peak_count, 4);
        checkOutput("fullStarts", start_count - s0, 6);
        checkOutput("fullRspCount", rsp_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            popRsp(r);
            checkOutput("fullInOrder", r, {8'(32'h20 + i), 8'(32'h60 + i)});
        end

        // Response backpressure with a write queued behind the read
        $display("[TB] response backpressure");
        rsp_ready = 1'b0;
        s0 = start_count;
        applyStimulus(1'b1, 8'h10, 8'h00);
        applyStimulus(1'b0, 8'h50, 8'h99);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bpValid", rsp_valid, 1);
        s1 = start_count;
        for (int i = 0; i < 7; i++) begin
            checkOutput("bpHold", {rsp_valid, rsp_addr, rsp_data}, {1'b1, 8'h10, 8'h3C});
            @(negedge clk);
        end
        checkOutput("bpNoStart", start_count - s1, 0);
        rsp_ready = 1'b1;
        waitIdle();
        checkOutput("bpStarts", start_count - s0, 2);
        checkOutput("bpWrite", stub_mem[8'h50], 8'h99);
        checkOutput("bpRspCount", rsp_q.size(), 1);
        popRsp(r);
        checkOutput("bpRspValue", r, {8'h10, 8'h3C});

        // Level-held done across two queued writes
        $display("[TB] stale done");
        stub_hold = 3;
        s0  = start_count;
        st0 = stale_starts;
        applyStimulus(1'b0, 8'h30, 8'h11);
        applyStimulus(1'b0, 8'h31, 8'h22);
        waitIdle();
        checkOutput("staleStarts", stale_starts - st0, 0);
        checkOutput("staleStartCount", start_count - s0, 2);
        checkOutput("staleMem30", stub_mem[8'h30], 8'h11);
        checkOutput("staleMem31", stub_mem[8'h31], 8'h22);
        checkOutput("staleNoRsp", rsp_q.size(), 0);
        stub_hold = 1;

        // Watchdog expiry: the read is never answered, the queued write runs
        $display("[TB] timeout");
        stub_skip = 1;
        s0 = start_count;
        applyStimulus(1'b1, 8'h40, 8'h00);
        waitStart();
        applyStimulus(1'b0, 8'h41, 8'h77);
        k = 1;
        while (!err_timeout && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput("toLatency", k, 9);
        waitIdle();
        checkOutput("toSticky", err_timeout, 1);
        checkOutput("toStarts", start_count - s0, 2);
        checkOutput("toNextWrite", stub_mem[8'h41], 8'h77);
        checkOutput("toNoRsp", rsp_q.size(), 0);

        // Asynchronous reset while waiting with two commands queued
        $display("[TB] reset mid-wait");
        stub_skip = 1;
        applyStimulus(1'b1, 8'h60, 8'h00);
        waitStart();
        applyStimulus(1'b0, 8'h61, 8'h01);
        applyStimulus(1'b0, 8'h62, 8'h02);
        checkOutput("preRstCount", count, 2);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("asyncRstFsm", {fsm_start, fsm_rw, fsm_addr, fsm_data_in}, 0);
        checkOutput("asyncRstRsp", {rsp_valid, rsp_addr, rsp_data}, 0);
        checkOutput("asyncRstCount", count, 0);
        checkOutput("asyncRstReady", cmd_ready, 1);
        checkOutput("asyncRstBusy", busy, 0);
        checkOutput("asyncRstErr", err_timeout, 0);
        @(negedge clk);
        reset_n = 1'b1;
        s1 = start_count;
        repeat (15) @(negedge clk);
        checkOutput("noStartAfterRst", start_count - s1, 0);
        checkOutput("idleAfterRst", busy, 0);
        applyStimulus(1'b0, 8'h63, 8'h5E);
        waitIdle();
        checkOutput("postRstStarts", start_count - s1, 1);
        checkOutput("postRstWrite", stub_mem[8'h63], 8'h5E);
        checkOutput("droppedWrite", stub_mem[8'h61], 8'hA1);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
